dram_responder: RTL and testbench
=================================

DRAM_RESPONDER -- requirements
Module: dram_responder

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 8: burst-word address width; memory holds 2^ADDR_BITS 288-bit words.
REQ-002 SHALL have parameter CMD_FIFO_DEPTH, default 16: command queue entries, power of two, >= 4.
REQ-003 SHALL have parameter RD_LATENCY, default 4: accept-to-first-read-beat cycles on an idle block, >= 3.
REQ-004 SHALL have port clk  input  1  sole clock, all logic on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port cmd_addr  input  32  burst-word address; bits above ADDR_BITS-1 ignored.
REQ-007 SHALL have port cmd_rnw  input  1  1 = read, 0 = write.
REQ-008 SHALL have port cmd_valid  input  1  command present this cycle.
REQ-009 SHALL have port wr_data  input  144  write beat data.
REQ-010 SHALL have port wr_be  input  18  write beat byte enables, bit n enables byte n.
REQ-011 SHALL have port rd_data  output  144  read beat data.
REQ-012 SHALL have port rd_valid  output  1  read beat valid.
REQ-013 SHALL have port fifo_ready  output  1  room for further commands.
REQ-014 SHALL have port err_overflow  output  1  sticky: command arrived with queue full.
REQ-015 SHALL have port err_protocol  output  1  sticky: command arrived in a write's second-beat cycle.

Function
REQ-016 SHALL accept a command in every cycle with cmd_valid=1, without handshake, unless REQ-021/REQ-022 applies.
REQ-017 Write SHALL take two beats: beat0 (bytes 0-17) in the command cycle, beat1 (bytes 18-35) in the next cycle; both beats and their enables are stored in one queue entry.
REQ-018 Queue SHALL be serviced in order, one entry per two cycles; a write updates only enabled bytes of mem[cmd_addr[ADDR_BITS-1:0]].
REQ-019 Read SHALL yield exactly two consecutive rd_valid beats: low 144 bits, then high 144 bits; reads return in command order and observe every earlier-accepted write (same address read-after-write returns new data).
REQ-020 Read issued to an idle block SHALL raise beat0 rd_valid exactly RD_LATENCY cycles after its accept cycle; back-to-back reads SHALL produce gap-free rd_valid streams.
REQ-021 Command with queue full SHALL be dropped, set err_overflow, and leave queue state unchanged.
REQ-022 Command during a write's beat1 cycle SHALL be dropped and set err_protocol; the write completes normally.
REQ-023 fifo_ready SHALL be 1 iff occupancy < CMD_FIFO_DEPTH-2 (two-entry slack for a master that registers fifo_ready); occupancy counts entries not yet serviced.
REQ-024 Simultaneous accept and service-pop SHALL leave occupancy unchanged; pointers wrap modulo CMD_FIFO_DEPTH.
REQ-025 rd_data SHALL be 0 whenever rd_valid=0.

Reset
REQ-026 rst_n=0 SHALL asynchronously clear queue pointers, occupancy, read pipeline, rd_valid, rd_data, fifo_ready, err_overflow, err_protocol.
REQ-027 fifo_ready SHALL first assert the first clock edge after rst_n deasserts; reads in flight at reset are discarded, no partial beats emitted.
REQ-028 Memory contents SHALL NOT be reset.

Configuration
REQ-029 With DRAM_RESPONDER_THROTTLE_EN defined, a 16-bit LFSR (seed 0xACE1, reset-loaded) SHALL additionally force fifo_ready=0 in cycles where its two LSBs are 00; without it fifo_ready follows REQ-023 only.

Structure
REQ-030 Shared package dram_responder_pkg SHALL hold the 144/288/18/36 data and enable widths, the queue entry struct and the LFSR seed/taps.
REQ-031 Command queue SHALL be a sub-module dram_responder_cmd_fifo (registered pointers, occupancy output); memory and read pipeline stay in the top.

Verification
REQ-032 Write addr 5, data all 0xA5, be all ones; read addr 5 -> two beats all 0xA5, beat0 at accept+4.
REQ-033 Fill addr 9 with 0x00, write beat0 be=0x00001 data 0xFF -> read gives byte 0 = 0xFF, others 0x00.
REQ-034 Reads to addr 1,2,3 every other cycle -> six contiguous rd_valid beats in order 1,2,3.
REQ-035 Issue 14 writes with service stalled by queue fill -> fifo_ready drops after 14th; 17th command in a full queue sets err_overflow.
REQ-036 Command in cycle after a write -> err_protocol=1, write still lands.
REQ-037 rst_n low during a read's beat0 -> rd_valid 0 immediately, no beat1 after release; with DRAM_RESPONDER_THROTTLE_EN fifo_ready low in LFSR-predicted cycles.

Source files
------------

// File: rtl/dram_responder_pkg.sv
// rtl/dram_responder_pkg.sv - shared widths, command queue entry and throttle LFSR constants
package dram_responder_pkg;

  localparam int BEAT_W    = 144;
  localparam int WORD_W    = 288;
  localparam int BEAT_BE_W = 18;
  localparam int WORD_BE_W = 36;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // One queued command; a write carries both beats and both enable halves.
  typedef struct packed {
    logic                 rnw;
    logic [31:0]          addr;
    logic [WORD_W-1:0]    data;
    logic [WORD_BE_W-1:0] be;
  } cmd_entry_t;

  // Right-shifting Galois LFSR step.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    lfsr_step = s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

endpackage

// File: rtl/dram_responder_cmd_fifo.sv
// rtl/dram_responder_cmd_fifo.sv - in-order command queue with registered pointers and occupancy
module dram_responder_cmd_fifo
  import dram_responder_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  cmd_entry_t                 push_data,
  input  logic                       pop,
  output cmd_entry_t                 head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  cmd_entry_t        slots [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage carries no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) slots[wr_ptr] <= push_data;
  end

  assign head  = slots[rd_ptr];
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/dram_responder.sv
// rtl/dram_responder.sv - DRAM model: command queue, 288-bit word memory, two-beat read pipeline
// Optional fifo_ready throttling LFSR is enabled by DRAM_RESPONDER_THROTTLE_EN.
module dram_responder
  import dram_responder_pkg::*;
#(
  parameter int ADDR_BITS      = 8,
  parameter int CMD_FIFO_DEPTH = 16,
  parameter int RD_LATENCY     = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          cmd_addr,
  input  logic                 cmd_rnw,
  input  logic                 cmd_valid,
  input  logic [BEAT_W-1:0]    wr_data,
  input  logic [BEAT_BE_W-1:0] wr_be,
  output logic [BEAT_W-1:0]    rd_data,
  output logic                 rd_valid,
  output logic                 fifo_ready,
  output logic                 err_overflow,
  output logic                 err_protocol
);

  localparam int CNT_W  = $clog2(CMD_FIFO_DEPTH) + 1;
  localparam int OCC_W  = CNT_W + 1;
  localparam int PIPE_N = RD_LATENCY - 2;
  localparam int WORDS  = 1 << ADDR_BITS;
  localparam logic [OCC_W-1:0] READY_LIMIT = OCC_W'(CMD_FIFO_DEPTH - 2);

  logic [WORD_W-1:0] mem [WORDS];

  cmd_entry_t        push_entry;
  cmd_entry_t        head;
  logic              push;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;

  logic                 wr_pend;
  logic [31:0]          wr_addr_q;
  logic [BEAT_W-1:0]    wr_data_q;
  logic [BEAT_BE_W-1:0] wr_be_q;

  logic svc_busy;
  logic ready_q;
  logic cmd_drop_proto;
  logic cmd_drop_full;
  logic cmd_accept;
  logic wr_start;
  logic rd_start;
  logic rd_fire;
  logic wr_fire;
  logic [ADDR_BITS-1:0] head_idx;
  logic [OCC_W-1:0]     occ_next;
  logic                 unused_addr_bits;

  assign cmd_drop_proto = cmd_valid & wr_pend;
  assign cmd_drop_full  = cmd_valid & ~wr_pend & fifo_full;
  assign cmd_accept     = cmd_valid & ~wr_pend & ~fifo_full;
  assign wr_start       = cmd_accept & ~cmd_rnw;
  assign rd_start       = cmd_accept & cmd_rnw;

  // A write enters the queue in its beat1 cycle, once both halves are known.
  assign push = rd_start | wr_pend;

  always_comb begin
    push_entry = '0;
    if (wr_pend) begin
      push_entry.rnw  = 1'b0;
      push_entry.addr = wr_addr_q;
      push_entry.data = {wr_data, wr_data_q};
      push_entry.be   = {wr_be, wr_be_q};
    end else begin
      push_entry.rnw  = 1'b1;
      push_entry.addr = cmd_addr;
    end
  end

  // Service slot: at most one pop every other cycle.
  assign pop      = ~fifo_empty & ~svc_busy;
  assign rd_fire  = pop & head.rnw;
  assign wr_fire  = pop & ~head.rnw;
  assign head_idx = head.addr[ADDR_BITS-1:0];
  assign unused_addr_bits = ^head.addr[31:ADDR_BITS];

  dram_responder_cmd_fifo #(
    .DEPTH (CMD_FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // A pending write beat1 counts as occupancy so fifo_ready never understates load.
  always_comb begin
    occ_next = {1'b0, fifo_count};
    if (push)     occ_next = occ_next + OCC_W'(1);
    if (pop)      occ_next = occ_next - OCC_W'(1);
    if (wr_start) occ_next = occ_next + OCC_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_pend      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      wr_be_q      <= '0;
      svc_busy     <= 1'b0;
      ready_q      <= 1'b0;
      err_overflow <= 1'b0;
      err_protocol <= 1'b0;
    end else begin
      wr_pend  <= wr_start;
      svc_busy <= pop;
      ready_q  <= (occ_next < READY_LIMIT);
      if (wr_start) begin
        wr_addr_q <= cmd_addr;
        wr_data_q <= wr_data;
        wr_be_q   <= wr_be;
      end
      if (cmd_drop_full)  err_overflow <= 1'b1;
      if (cmd_drop_proto) err_protocol <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      for (int b = 0; b < WORD_BE_W; b++) begin
        if (head.be[b]) mem[head_idx][8*b +: 8] <= head.data[8*b +: 8];
      end
    end
  end

  // Read data is captured at service time so later writes cannot disturb it.
  logic [PIPE_N-1:0] pipe_v;
  logic [WORD_W-1:0] pipe_d [PIPE_N];
  logic              hi_v;
  logic [BEAT_W-1:0] hi_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_v <= '0;
      for (int i = 0; i < PIPE_N; i++) pipe_d[i] <= '0;
      hi_v     <= 1'b0;
      hi_q     <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      pipe_v[0] <= rd_fire;
      pipe_d[0] <= rd_fire ? mem[head_idx] : '0;
      for (int i = 1; i < PIPE_N; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_d[i] <= pipe_d[i-1];
      end
      hi_v <= pipe_v[PIPE_N-1];
      hi_q <= pipe_v[PIPE_N-1] ? pipe_d[PIPE_N-1][WORD_W-1:BEAT_W] : '0;
      if (pipe_v[PIPE_N-1]) begin
        rd_valid <= 1'b1;
        rd_data  <= pipe_d[PIPE_N-1][BEAT_W-1:0];
      end else if (hi_v) begin
        rd_valid <= 1'b1;
        rd_data  <= hi_q;
      end else begin
        rd_valid <= 1'b0;
        rd_data  <= '0;
      end
    end
  end

`ifdef DRAM_RESPONDER_THROTTLE_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr <= LFSR_SEED;
    else        lfsr <= lfsr_step(lfsr);
  end

  assign fifo_ready = ready_q & (lfsr[1:0] != 2'b00);
`else
  assign fifo_ready = ready_q;
`endif

endmodule

// File: tb/tb_dram_responder.sv
// tb/tb_dram_responder.sv - self-checking bench for dram_responder
module tb_dram_responder;

  localparam int ADDR_BITS = 8;
  localparam int DEPTH     = 16;
  localparam int RL        = 4;
  localparam int WORDS     = 1 << ADDR_BITS;

  logic         clk       = 1'b0;
  logic         rst_n     = 1'b0;
  logic [31:0]  cmd_addr  = '0;
  logic         cmd_rnw   = 1'b0;
  logic         cmd_valid = 1'b0;
  logic [143:0] wr_data   = '0;
  logic [17:0]  wr_be     = '0;
  logic [143:0] rd_data;
  logic         rd_valid;
  logic         fifo_ready;
  logic         err_overflow;
  logic         err_protocol;

  always #5 clk = ~clk;

  dram_responder #(
    .ADDR_BITS      (ADDR_BITS),
    .CMD_FIFO_DEPTH (DEPTH),
    .RD_LATENCY     (RL)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_addr     (cmd_addr),
    .cmd_rnw      (cmd_rnw),
    .cmd_valid    (cmd_valid),
    .wr_data      (wr_data),
    .wr_be        (wr_be),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .fifo_ready   (fifo_ready),
    .err_overflow (err_overflow),
    .err_protocol (err_protocol)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [287:0] act, input logic [287:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: queue of commands, memory array, schedule of due read beats.
  typedef struct {
    bit           rnw;
    int unsigned  idx;
    logic [287:0] data;
    logic [35:0]  be;
  } ent_t;

  typedef struct {
    longint       due;
    logic [143:0] data;
  } beat_t;

  ent_t         q[$];
  beat_t        beats[$];
  logic [287:0] mmem [WORDS];
  bit           pend;
  int unsigned  pend_idx;
  logic [143:0] pend_d;
  logic [17:0]  pend_be;
  longint       cyc      = 0;
  longint       last_pop = -10;
  bit           m_ovf;
  bit           m_proto;
  logic [15:0]  m_lfsr   = 16'hACE1;

  function automatic logic [143:0] rand144();
    logic [159:0] r;
    r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return r[143:0];
  endfunction

  task automatic step(input logic v, input logic rnw, input logic [31:0] addr,
                      input logic [143:0] d, input logic [17:0] be);
    int    sz;
    ent_t  e;
    beat_t bt;
    logic [287:0] w;
    bit    exp_v;
    logic [143:0] exp_d;
    bit    exp_r;
    cmd_valid = v;
    cmd_rnw   = rnw;
    cmd_addr  = addr;
    wr_data   = d;
    wr_be     = be;
    @(posedge clk);
    sz = q.size();
    if (sz > 0 && cyc - last_pop >= 2) begin
      e = q.pop_front();
      last_pop = cyc;
      if (e.rnw) begin
        w = mmem[e.idx];
        bt.due = cyc + RL - 1; bt.data = w[143:0];   beats.push_back(bt);
        bt.due = cyc + RL;     bt.data = w[287:144]; beats.push_back(bt);
      end else begin
        for (int b = 0; b < 36; b++)
          if (e.be[b]) mmem[e.idx][8*b +: 8] = e.data[8*b +: 8];
      end
    end
    if (pend) begin
      if (v) m_proto = 1'b1;
      e.rnw = 1'b0; e.idx = pend_idx; e.data = {d, pend_d}; e.be = {be, pend_be};
      q.push_back(e);
      pend = 1'b0;
    end else if (v) begin
      if (sz == DEPTH) m_ovf = 1'b1;
      else if (rnw) begin
        e.rnw = 1'b1; e.idx = addr % WORDS; e.data = '0; e.be = '0;
        q.push_back(e);
      end else begin
        pend = 1'b1; pend_idx = addr % WORDS; pend_d = d; pend_be = be;
      end
    end
    m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
    cyc++;
    exp_v = 1'b0;
    exp_d = '0;
    if (beats.size() > 0 && beats[0].due == cyc) begin
      bt = beats.pop_front();
      exp_v = 1'b1;
      exp_d = bt.data;
    end
    exp_r = (q.size() + (pend ? 1 : 0)) < DEPTH - 2;
`ifdef DRAM_RESPONDER_THROTTLE_EN
    if (m_lfsr[1:0] == 2'b00) exp_r = 1'b0;
`endif
    #1;
    check($sformatf("rd_valid@%0d", cyc), rd_valid, exp_v);
    check($sformatf("rd_data@%0d", cyc), rd_data, exp_d);
    check($sformatf("fifo_ready@%0d", cyc), fifo_ready, exp_r);
    check($sformatf("err_overflow@%0d", cyc), err_overflow, m_ovf);
    check($sformatf("err_protocol@%0d", cyc), err_protocol, m_proto);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 32'd0, '0, '0);
  endtask

  task automatic do_reset();
    cmd_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("reset rd_valid", rd_valid, 1'b0);
    check("reset rd_data", rd_data, '0);
    check("reset fifo_ready", fifo_ready, 1'b0);
    check("reset err_overflow", err_overflow, 1'b0);
    check("reset err_protocol", err_protocol, 1'b0);
    q.delete();
    beats.delete();
    pend = 1'b0; m_ovf = 1'b0; m_proto = 1'b0; m_lfsr = 16'hACE1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("fifo_ready before first edge", fifo_ready, 1'b0);
    cyc = 0;
    last_pop = -10;
  endtask

  typedef struct packed {
    logic [31:0]  addr;
    logic [7:0]   pat;
    logic [35:0]  be;
    logic [287:0] exp;
  } vec_t;

  vec_t tbl [6];

  initial begin
    int first, last, nbeat;

    tbl[0] = '{32'd5,          8'hA5, 36'hF_FFFF_FFFF, {36{8'hA5}}};
    tbl[1] = '{32'd9,          8'h00, 36'hF_FFFF_FFFF, {36{8'h00}}};
    tbl[2] = '{32'd9,          8'hFF, 36'h0_0000_0001, {{35{8'h00}}, 8'hFF}};
    tbl[3] = '{32'd9,          8'h11, 36'h8_0000_0000, {8'h11, {34{8'h00}}, 8'hFF}};
    tbl[4] = '{32'h0000_0105,  8'h3C, 36'h0_000C_0000, {{16{8'hA5}}, 8'h3C, 8'h3C, {18{8'hA5}}}};
    tbl[5] = '{32'hFFFF_FF09,  8'h77, 36'h0_0000_0000, {8'h11, {34{8'h00}}, 8'hFF}};

    do_reset();

    // Directed write/read vectors, checking read latency and beat contents.
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b0, tbl[i].addr, {18{tbl[i].pat}}, tbl[i].be[17:0]);
      step(1'b0, 1'b0, 32'd0, {18{tbl[i].pat}}, tbl[i].be[35:18]);
      idle(6);
      step(1'b1, 1'b1, tbl[i].addr, '0, '0);
      idle(RL - 2);
      check($sformatf("vec%0d no early beat", i), rd_valid, 1'b0);
      idle(1);
      check($sformatf("vec%0d beat0 valid", i), rd_valid, 1'b1);
      check($sformatf("vec%0d beat0 data", i), rd_data, tbl[i].exp[143:0]);
      idle(1);
      check($sformatf("vec%0d beat1 valid", i), rd_valid, 1'b1);
      check($sformatf("vec%0d beat1 data", i), rd_data, tbl[i].exp[287:144]);
      idle(1);
      check($sformatf("vec%0d stream ends", i), rd_valid, 1'b0);
    end

    // Reset during beat0: output drops at once, beat1 never appears, memory survives.
    step(1'b1, 1'b1, 32'd5, '0, '0);
    idle(RL - 1);
    check("pre-reset beat0 valid", rd_valid, 1'b1);
    do_reset();
    idle(10);
    step(1'b1, 1'b1, 32'd5, '0, '0);
    idle(RL - 1);
    check("retained mem beat0", rd_data, tbl[4].exp[143:0]);
    idle(4);

    // Command in a write's beat1 cycle is dropped; the write still lands.
    step(1'b1, 1'b0, 32'd7, {18{8'h5A}}, 18'h3FFFF);
    step(1'b1, 1'b1, 32'd7, {18{8'hC3}}, 18'h3FFFF);
    check("protocol error flagged", err_protocol, 1'b1);
    idle(4);
    step(1'b1, 1'b1, 32'd7, '0, '0);
    idle(RL - 1);
    check("protocol write beat0", rd_data, {18{8'h5A}});
    idle(1);
    check("protocol write beat1", rd_data, {18{8'hC3}});
    idle(4);
    do_reset();

    // Give every word a known value.
    for (int a = 0; a < WORDS; a++) begin
      step(1'b1, 1'b0, a, rand144(), 18'h3FFFF);
      step(1'b0, 1'b0, 32'd0, rand144(), 18'h3FFFF);
    end
    idle(6);

    // Reads to 1,2,3 every other cycle form one gap-free six-beat stream.
    first = -1; last = -1; nbeat = 0;
    for (int k = 0; k < 16; k++) begin
      if (k == 0 || k == 2 || k == 4) step(1'b1, 1'b1, 32'(k / 2 + 1), '0, '0);
      else idle(1);
      if (rd_valid) begin
        if (first < 0) first = k;
        last = k;
        nbeat++;
      end
    end
    check("burst beat count", nbeat, 6);
    check("burst contiguous", last - first + 1, 6);
    idle(4);

    // Fill the queue with back-to-back reads until a command meets a full queue.
    do_reset();
    for (int k = 0; k < 34; k++) begin
      step(1'b1, 1'b1, 32'(k), '0, '0);
`ifndef DRAM_RESPONDER_THROTTLE_EN
      if (k == 25) check("ready at occupancy 13", fifo_ready, 1'b1);
      if (k == 26) check("ready drops at occupancy 14", fifo_ready, 1'b0);
`endif
      if (k == 30) check("no overflow before full", err_overflow, 1'b0);
      if (k == 31) check("overflow on full queue", err_overflow, 1'b1);
    end
    idle(50);
    do_reset();

    // Randomized traffic against the model.
    for (int k = 0; k < 1500; k++) begin
      step($urandom_range(0, 99) < 45, 1'($urandom()), $urandom(), rand144(), 18'($urandom()));
    end
    idle(50);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
